// File: rtl/pio_svc_pkg.sv
// Shared types and constants for the PIO edge-service controller:
// FSM state encoding, PIO register offsets and the event record layout.
package pio_svc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_EDGE,
        ST_WAIT_EDGE,
        ST_RD_LVL,
        ST_WAIT_LVL,
        ST_CLR,
        ST_PUSH
    } svc_state_e;

    localparam logic [1:0] OFS_DATA = 2'd0;
    localparam logic [1:0] OFS_EDGE = 2'd3;

    // Fields are sized for the widest PIO; bits above WIDTH stay zero.
    typedef struct packed {
        logic [31:0] level;
        logic [31:0] edges;
    } evt_rec_t;

endpackage

// File: rtl/pio_svc_poll_timer.sv
// Poll timer for the PIO edge-service controller: free-running down-counter,
// one-cycle tick at zero, pending flag and saturating missed-tick counter.
module pio_svc_poll_timer
    import pio_svc_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    output logic       tick_o,
    output logic       pending_o,
    output logic [7:0] missed_ticks_o
);

    localparam int unsigned CW = $clog2(POLL_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(POLL_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic [7:0]    missed_q, missed_d;

    // Next-state: counter reload, pending set/clear, missed-tick saturation.
    always_comb begin
        tick_o = (cnt_q == '0);
        cnt_d  = tick_o ? RELOAD : cnt_q - CW'(1);
        // Leaving IDLE consumes the old request; a tick in that same cycle
        // re-arms the flag only if it was not the tick that started the sequence.
        pending_d = start_i ? (tick_o & pending_q) : (pending_q | tick_o);
        missed_d  = missed_q;
        if (tick_o && pending_q && !start_i && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
            missed_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            missed_q  <= missed_d;
        end
    end

    assign pending_o      = pending_q;
    assign missed_ticks_o = missed_q;

endmodule

// File: rtl/pio_edge_service_ctrl.sv
// Avalon-MM master servicing an edge-capturing input PIO: on each poll tick it
// reads the edge register, reads the level register, clears the captured bits
// and emits one {level, edges} record on a valid/ready stream.
// Optional macro PIO_SVC_IRQ_EN adds input pio_irq, which starts a sequence
// directly from IDLE (the poll timer remains as a fallback).
module pio_edge_service_ctrl
    import pio_svc_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned POLL_CYCLES  = 50000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
`ifdef PIO_SVC_IRQ_EN
    input  logic             pio_irq,
`endif
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_level,
    output logic [WIDTH-1:0] evt_edges,
    output logic [7:0]       missed_ticks
);

    svc_state_e  state_q, state_d;
    logic [1:0]  wcnt_q, wcnt_d;
    evt_rec_t    rec_q, rec_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        tick, pending, irq_req, go, start;
    logic [WIDTH-1:0] rd_bits;
    logic [31:0] unused_readdata;
    logic [31:0] unused_level;

`ifdef PIO_SVC_IRQ_EN
    assign irq_req = pio_irq;
`else
    assign irq_req = 1'b0;
`endif

    // Only the low WIDTH bits of the PIO are meaningful; the rest are dropped.
    assign rd_bits         = avm_readdata[WIDTH-1:0];
    assign unused_readdata = avm_readdata;
    assign unused_level    = rec_q.level;

    // The tick itself counts as a request so a sequence can start in the tick cycle.
    assign go    = (pending | tick | irq_req) & enable;
    assign start = (state_q == ST_IDLE) & go;

    pio_svc_poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_timer (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .tick_o         (tick),
        .pending_o      (pending),
        .missed_ticks_o (missed_ticks)
    );

    // Next-state logic; bus strobes are derived from the next state so the
    // registered outputs line up with the state that owns the access.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rec_d   = rec_q;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_RD_EDGE;
            end
            ST_RD_EDGE: begin
                wcnt_d  = 2'd1;
                state_d = ST_WAIT_EDGE;
            end
            ST_WAIT_EDGE: begin
                if (wcnt_q == 2'(READ_LATENCY)) begin
                    rec_d.edges = 32'(rd_bits);
                    state_d     = (rd_bits == '0) ? ST_IDLE : ST_RD_LVL;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            ST_RD_LVL: begin
                wcnt_d  = 2'd1;
                state_d = ST_WAIT_LVL;
            end
            ST_WAIT_LVL: begin
                if (wcnt_q == 2'(READ_LATENCY)) begin
                    rec_d.level = 32'(rd_bits);
                    state_d     = ST_CLR;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            ST_CLR: begin
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                if (evt_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = OFS_DATA;
        wdata_d = '0;
        case (state_d)
            ST_RD_EDGE: begin
                cs_d   = 1'b1;
                addr_d = OFS_EDGE;
            end
            ST_RD_LVL: begin
                cs_d   = 1'b1;
                addr_d = OFS_DATA;
            end
            ST_CLR: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = OFS_EDGE;
                wdata_d = rec_d.edges;
            end
            default: ;
        endcase
    end

    // FSM, record and registered bus outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            rec_q   <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rec_q   <= rec_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign evt_valid      = (state_q == ST_PUSH);
    assign evt_level      = rec_q.level[WIDTH-1:0];
    assign evt_edges      = rec_q.edges[WIDTH-1:0];

endmodule

// File: tb/tb_pio_edge_service_ctrl.sv
// Testbench for pio_edge_service_ctrl (WIDTH=4, POLL_CYCLES=8, READ_LATENCY=1).
// A PIO slave model answers reads one cycle later; a monitor pops expected
// writes and event records from queues filled by the directed stimulus.
module tb_pio_edge_service_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          evt_ready = 1'b1;
`ifdef PIO_SVC_IRQ_EN
    logic          pio_irq = 1'b0;
`endif
    logic [1:0]    avm_address;
    logic          avm_chipselect, avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata = '0;
    logic          evt_valid;
    logic [W-1:0]  evt_level, evt_edges;
    logic [7:0]    missed_ticks;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    int wr_count = 0;
    int unsigned cyc = 0;

    logic [31:0] pio_edge = '0;
    logic [31:0] pio_level = '0;

    logic [33:0] exp_wr[$];
    logic [7:0]  exp_evt[$];
    logic [33:0] ew;
    logic [7:0]  ee;

    pio_edge_service_ctrl #(
        .WIDTH(W),
        .POLL_CYCLES(8),
        .READ_LATENCY(1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
`ifdef PIO_SVC_IRQ_EN
        .pio_irq        (pio_irq),
`endif
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_level      (evt_level),
        .evt_edges      (evt_edges),
        .missed_ticks   (missed_ticks)
    );

    // Cycle index since the last reset edge; cycle 7 carries the first tick.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // PIO slave: read data valid in the cycle after the read strobe.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 2'd3) ? pio_edge : pio_level;
    end

    // Monitor: every write and every accepted record must match the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (avm_chipselect && avm_write_n) rd_count++;
            if (avm_chipselect && !avm_write_n) begin
                wr_count++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%h, none expected", avm_address, avm_writedata);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({avm_address, avm_writedata} !== ew) begin
                        errors++;
                        $display("FAIL wr_data: got addr=%0d data=%h, exp addr=%0d data=%h",
                                 avm_address, avm_writedata, ew[33:32], ew[31:0]);
                    end
                end
            end
            if (evt_valid && evt_ready) begin
                checks++;
                if (exp_evt.size() == 0) begin
                    errors++;
                    $display("FAIL evt_unexpected: got level=%h edges=%h", evt_level, evt_edges);
                end else begin
                    ee = exp_evt.pop_front();
                    if ({evt_level, evt_edges} !== ee) begin
                        errors++;
                        $display("FAIL evt_data: got level=%h edges=%h, exp level=%h edges=%h",
                                 evt_level, evt_edges, ee[7:4], ee[3:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, exp %h", name, got, exp);
        end
    endtask

    // Advance to the sampling point (negedge) of cycle k.
    task automatic goto_check(input int unsigned k);
        int n = 0;
        @(negedge clk);
        while (cyc != k && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (cyc != k) begin
            checks++;
            errors++;
            $display("FAIL timeout_check: cyc=%0d, exp %0d", cyc, k);
        end
    endtask

    // Advance to the drive point (posedge + 1) at the start of cycle k.
    task automatic goto_drive(input int unsigned k);
        int n = 0;
        @(posedge clk); #1;
        while (cyc != k && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (cyc != k) begin
            checks++;
            errors++;
            $display("FAIL timeout_drive: cyc=%0d, exp %0d", cyc, k);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rdc, wdc;
        logic stable;

        // Test 1: basic sequence, edge=5 level=A.
        enable = 1'b1; evt_ready = 1'b1;
        pio_edge = 32'h5; pio_level = 32'hA;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        goto_check(0);
        chk("reset_bus", {avm_chipselect, avm_write_n, avm_address}, {1'b0, 1'b1, 2'd0});
        chk("reset_wdata", avm_writedata, 32'h0);
        chk("reset_evt", {evt_valid, evt_level, evt_edges}, 9'h0);
        chk("reset_missed", missed_ticks, 8'd0);
        exp_wr.push_back({2'd3, 32'h5});
        exp_evt.push_back({4'hA, 4'h5});
        goto_check(8);
        chk("t1_rd_edge", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd3});
        goto_check(10);
        chk("t1_rd_lvl", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd0});
        goto_check(12);
        chk("t1_valid_early", evt_valid, 1'b0);
        goto_check(13);
        chk("t1_valid_latency", {evt_valid, evt_level, evt_edges}, {1'b1, 4'hA, 4'h5});
        goto_drive(14);
        pio_edge = 32'h0;

        // Test 2: empty edge register -> single read, no clear, no event.
        goto_check(15);
        rdc = rd_count; wdc = wr_count;
        goto_check(16);
        chk("t2_rd_edge", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd3});
        stable = 1'b1;
        for (int unsigned k = 17; k <= 22; k++) begin
            goto_check(k);
            if (avm_chipselect || evt_valid) stable = 1'b0;
        end
        chk("t2_quiet", stable, 1'b1);
        chk("t2_one_read", rd_count - rdc, 1);
        chk("t2_no_write", wr_count - wdc, 0);

        // Test 3: backpressure for 40 cycles, then one sequence from pending.
        goto_drive(23);
        pio_edge = 32'h3; pio_level = 32'hC; evt_ready = 1'b0;
        exp_wr.push_back({2'd3, 32'h3});
        exp_evt.push_back({4'hC, 4'h3});
        exp_wr.push_back({2'd3, 32'h9});
        exp_evt.push_back({4'h6, 4'h9});
        goto_check(24);
        chk("t3_rd_edge", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd3});
        goto_check(28);
        chk("t3_clr", {avm_chipselect, avm_write_n, avm_address, avm_writedata},
            {1'b1, 1'b0, 2'd3, 32'h3});
        goto_check(29);
        chk("t3_valid", {evt_valid, evt_level, evt_edges}, {1'b1, 4'hC, 4'h3});
        goto_drive(30);
        pio_edge = 32'h9; pio_level = 32'h6;
        stable = 1'b1;
        for (int unsigned k = 30; k <= 68; k++) begin
            goto_check(k);
            if (!(evt_valid && evt_level == 4'hC && evt_edges == 4'h3)) stable = 1'b0;
        end
        chk("t3_hold_stable", stable, 1'b1);
        goto_drive(69);
        evt_ready = 1'b1;
        goto_check(69);
        chk("t3_missed", missed_ticks, 8'd4);
        goto_check(70);
        chk("t3_idle_after_xfer", {evt_valid, avm_chipselect}, 2'b00);
        goto_check(71);
        chk("t3_extra_rd_edge", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd3});
        goto_drive(73);
        pio_edge = 32'h0;
        goto_check(76);
        chk("t3_extra_evt", {evt_valid, evt_level, evt_edges}, {1'b1, 4'h6, 4'h9});
        goto_check(90);
        chk("t3_drained", exp_wr.size() + exp_evt.size(), 0);

        // Test 4: disabled across three ticks, then enabled.
        enable = 1'b0; pio_edge = 32'h1; pio_level = 32'hF;
        do_reset();
        rdc = rd_count;
        goto_check(25);
        chk("t4_no_bus", rd_count - rdc, 0);
        chk("t4_missed", missed_ticks, 8'd2);
        exp_wr.push_back({2'd3, 32'h1});
        exp_evt.push_back({4'hF, 4'h1});
        goto_drive(26);
        enable = 1'b1;
        goto_check(26);
        chk("t4_cs_before", avm_chipselect, 1'b0);
        goto_check(27);
        chk("t4_rd_edge", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd3});
        goto_drive(28);
        pio_edge = 32'h0;
        goto_check(32);
        chk("t4_evt", {evt_valid, evt_level, evt_edges}, {1'b1, 4'hF, 4'h1});
        goto_check(40);

        // Test 5: reset during WAIT_LVL aborts without a clear write.
        enable = 1'b1; pio_edge = 32'h2; pio_level = 32'h7;
        do_reset();
        wdc = wr_count;
        goto_check(10);
        chk("t5_rd_lvl", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd0});
        goto_drive(11);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_abort", {avm_chipselect, avm_write_n, evt_valid}, {1'b0, 1'b1, 1'b0});
        chk("t5_missed", missed_ticks, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0; enable = 1'b0;
        goto_check(20);
        chk("t5_no_clr", wr_count - wdc, 0);

`ifdef PIO_SVC_IRQ_EN
        // Test 6: interrupt starts a sequence without waiting for a tick.
        enable = 1'b1; pio_edge = 32'h4; pio_level = 32'hB;
        do_reset();
        exp_wr.push_back({2'd3, 32'h4});
        exp_evt.push_back({4'hB, 4'h4});
        goto_drive(3);
        pio_irq = 1'b1;
        goto_check(3);
        chk("t6_cs_before", avm_chipselect, 1'b0);
        goto_drive(4);
        pio_irq = 1'b0;
        goto_check(4);
        chk("t6_rd_edge", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 2'd3});
        goto_drive(5);
        pio_edge = 32'h0;
        goto_check(9);
        chk("t6_evt", {evt_valid, evt_level, evt_edges}, {1'b1, 4'hB, 4'h4});
        goto_check(30);
`endif

        chk("final_drained", exp_wr.size() + exp_evt.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
